// File: rtl/sweep_game_ctrl_if.sv
// Draw request/done handshake between the garbage-press game sequencer and the draw block.
interface sweep_game_ctrl_if #(
    parameter int POS_W = 3
);
    logic             draw_req;
    logic             draw_erase;
    logic             draw_item;
    logic [POS_W-1:0] draw_pos;
    logic             draw_done;

    modport master (output draw_req, draw_erase, draw_item, draw_pos, input draw_done);
    modport slave  (input draw_req, draw_erase, draw_item, draw_pos, output draw_done);
endinterface

// File: rtl/sweep_game_ctrl.sv
// Garbage-press game sequencer: sweeps the press, spawns garbage, scores hits, counts misses.
// Define SWEEP_GAME_BCD_SCORE_EN for a packed-BCD score instead of a saturating binary one.
module sweep_game_ctrl #(
    parameter int NUM_POS     = 6,
    parameter int POS_W       = 3,
    parameter int SCORE_W     = 8,
    parameter int MISS_W      = 2,
    parameter int MAX_MISSES  = 3,
    parameter int STEP_CYCLES = 50000000
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               start,
    input  logic               hit_n,
    input  logic [POS_W-1:0]   rng,
    sweep_game_ctrl_if.master  draw,
    output logic [POS_W-1:0]   press_pos,
    output logic [POS_W-1:0]   garb_pos,
    output logic               garb_valid,
    output logic [SCORE_W-1:0] score,
    output logic [MISS_W-1:0]  misses,
    output logic               game_over,
    output logic               hit_pulse
);
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_LAST  = POS_W'(NUM_POS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE_GARB, S_DRAW_GARB, S_ERASE_PRESS, S_DRAW_PRESS, S_PLAY, S_OVER
    } state_t;
    typedef enum logic [1:0] {M_INIT, M_RESTART, M_RUN} mode_t;

    state_t state;
    mode_t  mode;

    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
`ifdef SWEEP_GAME_BCD_SCORE_EN
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = s;
        carry = 1'b1;
        for (int i = 0; i < SCORE_W / 4; i++) begin
            if (carry) begin
                if (s[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = s[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        // A carry out of the top nibble means every digit was 9: hold there.
        return carry ? s : r;
`else
        return (&s) ? s : s + 1'b1;
`endif
    endfunction

    logic hit_sync_p0, hit_sync_p1, hit_prev_p2;
    logic hit_ev;
    logic [CNT_W-1:0] tick_cnt;
    logic counting, tick, tick_pend;
    logic [POS_W-1:0] garb_new, press_next, req_pos;
    logic [MISS_W-1:0] miss_next;
    logic is_draw, req_erase, req_item;

    assign hit_ev     = hit_prev_p2 & ~hit_sync_p1;
    assign counting   = (state != S_IDLE) && (state != S_OVER);
    assign tick       = counting && (tick_cnt == TICK_LAST);
    assign garb_new   = ({1'b0, rng} < (POS_W+1)'(NUM_POS)) ? rng : rng - POS_W'(NUM_POS);
    assign press_next = (press_pos == POS_LAST) ? '0 : press_pos + 1'b1;
    assign miss_next  = misses + 1'b1;
    assign req_pos    = req_item ? press_pos : garb_pos;

    always_comb begin
        is_draw   = 1'b0;
        req_erase = 1'b0;
        req_item  = 1'b0;
        case (state)
            S_ERASE_GARB:  begin is_draw = 1'b1; req_erase = 1'b1; end
            S_DRAW_GARB:   begin is_draw = 1'b1; end
            S_ERASE_PRESS: begin is_draw = 1'b1; req_erase = 1'b1; req_item = 1'b1; end
            S_DRAW_PRESS:  begin is_draw = 1'b1; req_item = 1'b1; end
            default:       ;
        endcase
    end

    // hit_n synchroniser, then the delayed copy for falling-edge detection
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            hit_sync_p0 <= 1'b1;
            hit_sync_p1 <= 1'b1;
            hit_prev_p2 <= 1'b1;
        end else begin
            hit_sync_p0 <= hit_n;
            hit_sync_p1 <= hit_sync_p0;
            hit_prev_p2 <= hit_sync_p1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n || !counting || tick_cnt == TICK_LAST) tick_cnt <= '0;
        else                                                tick_cnt <= tick_cnt + 1'b1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            mode            <= M_INIT;
            tick_pend       <= 1'b0;
            press_pos       <= '0;
            garb_pos        <= '0;
            garb_valid      <= 1'b0;
            score           <= '0;
            misses          <= '0;
            game_over       <= 1'b0;
            hit_pulse       <= 1'b0;
            draw.draw_req   <= 1'b0;
            draw.draw_erase <= 1'b0;
            draw.draw_item  <= 1'b0;
            draw.draw_pos   <= '0;
        end else begin
            hit_pulse <= 1'b0;
            if (tick) tick_pend <= 1'b1;
            // Each draw state idles one cycle with req low, then holds the request until done.
            if (is_draw) begin
                if (!draw.draw_req) begin
                    draw.draw_req   <= 1'b1;
                    draw.draw_erase <= req_erase;
                    draw.draw_item  <= req_item;
                    draw.draw_pos   <= req_pos;
                end else if (draw.draw_done) begin
                    draw.draw_req <= 1'b0;
                    case (state)
                        S_ERASE_GARB: begin
                            garb_pos <= garb_new;
                            state    <= S_DRAW_GARB;
                        end
                        S_DRAW_GARB: begin
                            case (mode)
                                M_INIT:    state <= S_DRAW_PRESS;
                                M_RESTART: state <= S_ERASE_PRESS;
                                default:   state <= S_PLAY;
                            endcase
                        end
                        S_ERASE_PRESS: begin
                            press_pos <= (mode == M_RESTART) ? '0 : press_next;
                            state     <= S_DRAW_PRESS;
                        end
                        default: begin
                            mode  <= M_RUN;
                            state <= S_PLAY;
                        end
                    endcase
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            garb_pos   <= garb_new;
                            garb_valid <= 1'b1;
                            press_pos  <= '0;
                            mode       <= M_INIT;
                            state      <= S_DRAW_GARB;
                        end
                    end
                    S_PLAY: begin
                        if (hit_ev && press_pos == garb_pos) begin
                            score     <= score_inc(score);
                            hit_pulse <= 1'b1;
                            state     <= S_ERASE_GARB;
                        end else if (hit_ev) begin
                            misses <= miss_next;
                            if (miss_next == MISS_W'(MAX_MISSES)) begin
                                game_over <= 1'b1;
                                state     <= S_OVER;
                            end
                        end else if (tick_pend) begin
                            // A tick landing on the service cycle stays pending.
                            tick_pend <= tick;
                            state     <= S_ERASE_PRESS;
                        end
                    end
                    S_OVER: begin
                        if (start) begin
                            score     <= '0;
                            misses    <= '0;
                            game_over <= 1'b0;
                            tick_pend <= 1'b0;
                            mode      <= M_RESTART;
                            state     <= S_ERASE_GARB;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sweep_game_ctrl.sv
// Scoreboard bench for sweep_game_ctrl: stimulus queues expected draw requests and scores,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sweep_game_ctrl;
    localparam int NUM_POS = 6, POS_W = 3, SCORE_W = 8, MISS_W = 2, MAX_MISSES = 3, STEP_CYCLES = 16;

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b0;
    logic start    = 1'b0;
    logic hit_n    = 1'b1;
    logic [POS_W-1:0]   rng = '0;
    logic [POS_W-1:0]   press_pos, garb_pos;
    logic               garb_valid, game_over, hit_pulse;
    logic [SCORE_W-1:0] score;
    logic [MISS_W-1:0]  misses;

    sweep_game_ctrl_if #(.POS_W(POS_W)) draw ();

    sweep_game_ctrl #(
        .NUM_POS(NUM_POS), .POS_W(POS_W), .SCORE_W(SCORE_W), .MISS_W(MISS_W),
        .MAX_MISSES(MAX_MISSES), .STEP_CYCLES(STEP_CYCLES)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .start(start), .hit_n(hit_n), .rng(rng),
        .draw(draw), .press_pos(press_pos), .garb_pos(garb_pos), .garb_valid(garb_valid),
        .score(score), .misses(misses), .game_over(game_over), .hit_pulse(hit_pulse)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int fails  = 0;
    bit abort  = 1'b0;
    logic [POS_W+1:0]   exp_draw[$];
    logic [SCORE_W-1:0] exp_score[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [SCORE_W-1:0] exp_score_val(input int k);
`ifdef SWEEP_GAME_BCD_SCORE_EN
        int m;
        m = (k > 99) ? 99 : k;
        return SCORE_W'(((m / 10) << 4) | (m % 10));
`else
        return SCORE_W'((k > 2**SCORE_W - 1) ? 2**SCORE_W - 1 : k);
`endif
    endfunction

    // Monitor: new requests, request stability at done, and hit pulses
    logic prev_req   = 1'b0;
    logic prev_pulse = 1'b0;
    logic [POS_W+1:0] cur_req = '0;
    always @(negedge CLOCK_50) begin
        if (reset_n && draw.draw_req && !prev_req) begin
            cur_req = {draw.draw_erase, draw.draw_item, draw.draw_pos};
            if (exp_draw.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_draw_req: got erase/item/pos %b, required no request", cur_req);
            end else begin
                check("draw_req_fields", 32'(cur_req), 32'(exp_draw.pop_front()));
            end
        end
        if (draw.draw_req && draw.draw_done)
            check("draw_req_stable", 32'({draw.draw_erase, draw.draw_item, draw.draw_pos}), 32'(cur_req));
        if (hit_pulse) begin
            check("hit_pulse_width", 32'(prev_pulse), 32'(0));
            if (!prev_pulse) begin
                if (exp_score.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_hit_pulse: got score %0h, required no hit", score);
                end else begin
                    check("score_on_hit", 32'(score), 32'(exp_score.pop_front()));
                end
            end
        end
        prev_req   = draw.draw_req;
        prev_pulse = hit_pulse;
    end

    // Drawer: expect one request, answer after dly extra cycles; optionally time a hit so
    // that hit_ev lands on the first cycle after done is sampled.
    task automatic serve(input logic e, input logic i, input logic [POS_W-1:0] p,
                         input int dly, input bit hit);
        int waited;
        if (abort) return;
        exp_draw.push_back({e, i, p});
        waited = 0;
        while (!draw.draw_req && waited < 200) begin
            @(posedge CLOCK_50); #1;
            waited++;
        end
        if (!draw.draw_req) begin
            checks++;
            fails++;
            $display("FAIL draw_req_timeout: got no request in 200 cycles, required erase=%0b item=%0b pos=%0d", e, i, p);
            abort = 1'b1;
            return;
        end
        repeat (dly) begin @(posedge CLOCK_50); #1; end
        if (hit) begin
            hit_n = 1'b0;
            @(posedge CLOCK_50); #1;
        end
        draw.draw_done = 1'b1;
        @(posedge CLOCK_50); #1;
        draw.draw_done = 1'b0;
        hit_n          = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
    endtask

    initial begin
        int p, g, g_next, hits;
        draw.draw_done = 1'b0;

        // Reset
        repeat (2) @(posedge CLOCK_50);
        #1;
        check("rst_draw_req", 32'(draw.draw_req), 32'(0));
        check("rst_draw_fields", 32'({draw.draw_erase, draw.draw_item, draw.draw_pos}), 32'(0));
        check("rst_press_pos", 32'(press_pos), 32'(0));
        check("rst_garb", 32'({garb_pos, garb_valid}), 32'(0));
        check("rst_score", 32'(score), 32'(0));
        check("rst_misses_over", 32'({misses, game_over, hit_pulse}), 32'(0));
        reset_n = 1'b1;
        repeat (20) @(posedge CLOCK_50);
        #1;
        check("idle_no_req", 32'(draw.draw_req), 32'(0));

        // Start: rng=7 -> garbage at 1, press at 0
        rng = 3'd7;
        pulse_start();
        serve(1'b0, 1'b0, 3'd1, 5, 1'b0);
        serve(1'b0, 1'b1, 3'd0, 0, 1'b0);
        check("play_press_pos", 32'(press_pos), 32'(0));
        check("play_garb_pos", 32'(garb_pos), 32'(1));
        check("play_garb_valid", 32'(garb_valid), 32'(1));

        // Slow press erases: ticks coalesce, one step per service
        for (int k = 0; k < NUM_POS; k++) begin
            serve(1'b1, 1'b1, POS_W'(k), 40, 1'b0);
            serve(1'b0, 1'b1, POS_W'((k + 1) % NUM_POS), 0, 1'b0);
            check("step_press_pos", 32'(press_pos), 32'((k + 1) % NUM_POS));
        end

        // Hit at pos 1 with a tick pending: garbage redraw first, then the press step
        serve(1'b1, 1'b1, 3'd0, 40, 1'b0);
        rng = 3'd4;
        exp_score.push_back(exp_score_val(1));
        serve(1'b0, 1'b1, 3'd1, 0, 1'b1);
        serve(1'b1, 1'b0, 3'd1, 0, 1'b0);
        serve(1'b0, 1'b0, 3'd4, 0, 1'b0);
        serve(1'b1, 1'b1, 3'd1, 0, 1'b0);
        check("score_after_hit", 32'(score), 32'(exp_score_val(1)));

        // Three misses against garbage at 4
        serve(1'b0, 1'b1, 3'd2, 0, 1'b1);
        serve(1'b1, 1'b1, 3'd2, 0, 1'b0);
        check("misses_1", 32'(misses), 32'(1));
        serve(1'b0, 1'b1, 3'd3, 0, 1'b1);
        serve(1'b1, 1'b1, 3'd3, 0, 1'b0);
        check("misses_2", 32'({misses, game_over}), 32'({2'd2, 1'b0}));
        serve(1'b0, 1'b1, 3'd4, 0, 1'b0);
        serve(1'b1, 1'b1, 3'd4, 0, 1'b0);
        serve(1'b0, 1'b1, 3'd5, 0, 1'b1);
        repeat (40) @(posedge CLOCK_50);
        #1;
        check("misses_3", 32'(misses), 32'(3));
        check("game_over", 32'(game_over), 32'(1));
        check("over_no_req", 32'(draw.draw_req), 32'(0));
        check("over_score_held", 32'(score), 32'(exp_score_val(1)));

        // Restart from OVER
        rng = 3'd2;
        pulse_start();
        serve(1'b1, 1'b0, 3'd4, 0, 1'b0);
        serve(1'b0, 1'b0, 3'd2, 0, 1'b0);
        serve(1'b1, 1'b1, 3'd5, 0, 1'b0);
        serve(1'b0, 1'b1, 3'd0, 0, 1'b0);
        check("restart_score", 32'(score), 32'(0));
        check("restart_misses_over", 32'({misses, game_over}), 32'(0));
        check("restart_pos", 32'({press_pos, garb_pos}), 32'({3'd0, 3'd2}));

        // Chase the garbage one step ahead until the score saturates
        p = 0; g = 2; hits = 0;
        while (hits < 2**SCORE_W && !abort) begin
            serve(1'b1, 1'b1, POS_W'(p), 0, 1'b0);
            p = (p + 1) % NUM_POS;
            if (p == g) begin
                g_next = (p + 1) % NUM_POS;
                rng    = POS_W'((g_next < 2) ? g_next + NUM_POS : g_next);
                hits++;
                exp_score.push_back(exp_score_val(hits));
                serve(1'b0, 1'b1, POS_W'(p), 0, 1'b1);
                serve(1'b1, 1'b0, POS_W'(g), 0, 1'b0);
                g = g_next;
                serve(1'b0, 1'b0, POS_W'(g), 0, 1'b0);
            end else begin
                serve(1'b0, 1'b1, POS_W'(p), 0, 1'b0);
            end
        end
        check("score_saturated", 32'(score), 32'(exp_score_val(2**SCORE_W)));
        check("score_queue_drained", 32'(exp_score.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/sweep_game_ctrl.md
Name: sweep_game_ctrl

Overview:
Parametrised game sequencer for the garbage-press game. It sweeps a press across NUM_POS positions, spawns garbage from an external RNG, and scores hits. It also counts misses up to a game-over limit. Drawing uses a req/done handshake with the draw block instead of fixed delay counts. Sits between KEY inputs, the random block, the draw block and the hex score display.

Parameters:
NUM_POS, 6, number of press/garbage positions (2..2^POS_W)
POS_W, 3, position width; 2^POS_W < 2*NUM_POS required
SCORE_W, 8, score width
MISS_W, 2, miss counter width
MAX_MISSES, 3, misses that end the game (1..2^MISS_W-1)
STEP_CYCLES, 50000000, CLOCK_50 cycles per press step

Ports:
CLOCK_50  in  1  system clock
reset_n  in  1  reset
start  in  1  one-cycle start/restart pulse
hit_n  in  1  raw active-low hit button
rng  in  POS_W  random value
draw_req  out  1  draw request
draw_erase  out  1  1=erase, 0=draw
draw_item  out  1  0=garbage, 1=press
draw_pos  out  POS_W  target position
draw_done  in  1  one-cycle pulse from drawer, only while draw_req=1
press_pos  out  POS_W  current press position
garb_pos  out  POS_W  current garbage position
garb_valid  out  1  garbage on screen
score  out  SCORE_W  score
misses  out  MISS_W  miss count
game_over  out  1  game ended
hit_pulse  out  1  one cycle on scoring hit

Behaviour:
- Reset: reset_n is synchronous, active-low, on CLOCK_50.
  - Outputs on reset: all outputs 0; FSM to IDLE; tick counter, pending flag and hit synchroniser cleared (synchroniser to 1).
  - Reset mid-draw drops draw_req next cycle; no drawer recovery needed.
- hit_n path: 2-flop synchroniser, then falling-edge detect gives hit_ev (1 cycle).
- Tick counter:
  - Counts 0..STEP_CYCLES-1 continuously; tick=1 on the terminal count.
  - Counter is frozen at 0 in IDLE and OVER.
- tick_pend:
  - Set by tick; cleared when PLAY services it.
  - Multiple ticks before service coalesce into one step.
- Garbage position: garb_new = rng if rng<NUM_POS, else rng-NUM_POS.
- Press step: next = press_pos+1, wrapping NUM_POS-1 -> 0.
- Handshake:
  - In every draw state, draw_req=1 with erase/item/pos stable until draw_done is sampled.
  - The state then advances and draw_req is 0 for at least 1 cycle before the next request.
- States:
  - IDLE: on start, garb_pos<=garb_new, garb_valid<=1, press_pos<=0, mode<=INIT, go DRAW_GARB.
  - ERASE_GARB (erase=1, item=0, pos=garb_pos): on done, garb_pos<=garb_new, go DRAW_GARB.
  - DRAW_GARB (erase=0, item=0, pos=garb_pos): on done, go to DRAW_PRESS if mode=INIT; ERASE_PRESS if mode=RESTART; PLAY if mode=RUN.
  - ERASE_PRESS (erase=1, item=1, pos=press_pos): on done, press_pos<=(mode=RESTART ? 0 : next), go DRAW_PRESS.
  - DRAW_PRESS (erase=0, item=1, pos=press_pos): on done, mode<=RUN, go PLAY.
  - PLAY, priority order:
    - hit_ev with press_pos==garb_pos: score+1 (saturating), hit_pulse=1, go ERASE_GARB.
    - hit_ev otherwise: misses+1; if the new value == MAX_MISSES, game_over<=1 and go OVER.
    - tick_pend: clear it, go ERASE_PRESS.
  - OVER: draw_req=0. On start: score, misses, game_over, tick_pend cleared; mode<=RESTART; go ERASE_GARB.
- Simultaneous events:
  - hit_ev outside PLAY is discarded.
  - start outside IDLE/OVER is ignored.
  - hit and tick together: hit wins, tick stays pending.
- Score saturates at the all-ones value (binary); it never wraps.

Optional Feature:
Macro: SWEEP_GAME_BCD_SCORE_EN.
- Defined: score is packed BCD, SCORE_W a multiple of 4. Increment carries per nibble (0x09 -> 0x10) and saturates at all-9s (0x99 for 8 bits).
- Undefined: plain binary score saturating at 2^SCORE_W-1.

Test Plan:
- Reset: after reset_n low for 2 cycles -> all outputs 0, draw_req never asserted without start.
- Start from IDLE, rng=7, NUM_POS=6:
  - draw_req with item=0, pos=1, erase=0; done after 5 cycles.
  - Then item=1, pos=0; done.
  - Then PLAY, garb_pos=1, press_pos=0.
- STEP_CYCLES=16; with the drawer stalling done for 40 cycles during ERASE_PRESS -> exactly one step per service, pending ticks coalesce, press sequence 0,1,2,3,4,5,0.
- hit_n falling edge with press_pos=garb_pos=1 -> score 0->1, hit_pulse 1 cycle, erase garb pos 1 then draw garb at rng-derived pos.
  - Same cycle as tick -> tick serviced after the garbage redraw.
- Three misaligned presses -> misses 1,2,3, game_over=1, no draw_req.
  - start -> erase garb, draw garb, erase old press, draw press at 0; score=0, misses=0.
- With SWEEP_GAME_BCD_SCORE_EN: score 0x09 + hit -> 0x10; 0x99 + hit -> 0x99. Without the macro: 0xFF + hit -> 0xFF.
